// File: rtl/display_timing_if.sv
// Raster timing bundle: control and offsets in, coordinates,
// syncs and screenshot status out.
interface display_timing_if;
  logic       enable;
  logic       shot_req;
  logic [9:0] x_offset;
  logic [9:0] y_offset;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic       frame_start;
  logic       shot_active;
  logic       shot_done;

  modport master (
    output enable, shot_req, x_offset, y_offset,
    input  x_pos, y_pos, scroll_x, scroll_y,
    input  hsync, vsync, blank, frame_start,
    input  shot_active, shot_done
  );

  modport slave (
    input  enable, shot_req, x_offset, y_offset,
    output x_pos, y_pos, scroll_x, scroll_y,
    output hsync, vsync, blank, frame_start,
    output shot_active, shot_done
  );
endinterface

// File: rtl/display_timing.sv
// Video raster generator with frame-aligned scroll offsets and
// an edge-armed single-frame screenshot window.
module display_timing #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  display_timing_if.slave  bus
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] xsh_q, xsh_d;
  logic [9:0] ysh_q, ysh_d;
  logic       armed_q, armed_d;
  logic       cap_q, cap_d;
  logic       done_q, done_d;
  logic       hold_q, hold_d;

  logic       run;
  logic       arm_ok;
  logic       eol;
  logic       eof;
  logic       fs;
  logic       arm;
  logic [9:0] xs;
  logic [9:0] ys;

  assign eol = (x_q == H_LAST);
  assign eof = eol && (y_q == V_LAST);
  assign fs  = run && (x_q == '0) && (y_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Leaving RUN on the last pixel goes straight to IDLE so a
  // fresh frame is never started just to be drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable) state_d = RUN;
      RUN:     if (!bus.enable) state_d = eof ? IDLE : DRAIN;
      DRAIN: begin
        if (bus.enable) state_d = RUN;
        else if (eof)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    arm_ok = 1'b0;
    unique case (state_q)
      IDLE:    ;
      RUN:     begin run = 1'b1; arm_ok = 1'b1; end
      DRAIN:   run = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (run) begin
      if (eol) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // hold_q blocks re-arming until shot_req has been seen low.
  assign arm = arm_ok && bus.shot_req && !hold_q;

  always_comb begin
    xsh_d   = fs ? bus.x_offset : xsh_q;
    ysh_d   = fs ? bus.y_offset : ysh_q;
    hold_d  = bus.shot_req && (hold_q || arm);
    armed_d = arm || (armed_q && !fs);
    if (state_d == IDLE) armed_d = 1'b0;
    cap_d   = cap_q;
    if (fs && armed_q) cap_d = 1'b1;
    else if (eof)      cap_d = 1'b0;
    done_d  = cap_q && eof;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      xsh_q   <= '0;
      ysh_q   <= '0;
      armed_q <= 1'b0;
      cap_q   <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      xsh_q   <= xsh_d;
      ysh_q   <= ysh_d;
      armed_q <= armed_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  // The frame_start clock already scrolls by the offsets being latched.
  assign xs = fs ? bus.x_offset : xsh_q;
  assign ys = fs ? bus.y_offset : ysh_q;

  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.scroll_x    = x_q + xs;
  assign bus.scroll_y    = y_q + ys;
  assign bus.frame_start = fs;
  assign bus.blank       = !(run && (x_q < H_VIS) && (y_q < V_VIS));
  assign bus.hsync       =
    (run && (x_q >= HS_BEG) && (x_q < HS_END)) ? SYNC_ACTIVE
                                               : !SYNC_ACTIVE;
  assign bus.vsync       =
    (run && (y_q >= VS_BEG) && (y_q < VS_END)) ? SYNC_ACTIVE
                                               : !SYNC_ACTIVE;
  assign bus.shot_active = cap_q || (fs && armed_q);
  assign bus.shot_done   = done_q;

endmodule

// File: tb/tb_display_timing.sv
// Directed bench for display_timing with a short 10-line frame
// and default horizontal timing (8000 clocks per frame).
module tb_display_timing;

  localparam int HT = 800;
  localparam int VT = 10;
  localparam int FR = HT * VT;

  logic clk;
  logic reset;

  display_timing_if bus ();

  display_timing #(
    .V_VISIBLE (6),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int f; int x; int y;
    int xo; int yo;
    bit hs; bit vs; bit bl; bit fs;
    int sx; int sy;
  } vec_t;

  vec_t vt [17];

  int pass_n = 0;
  int tot_n  = 0;
  int act_n  = 0;
  int done_n = 0;
  int done_t = -1;
  int t      = 0;
  int d0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    tot_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (bus.shot_active) act_n++;
    if (bus.shot_done) begin
      done_n++;
      done_t = t;
    end
  endtask

  task automatic goto(int f, int x, int y);
    int tg;
    tg = f * FR + y * HT + x;
    if (tg < t) begin
      tot_n++;
      $display("FAIL goto: at %0d want %0d", t, tg);
    end else begin
      while (t < tg) tick();
    end
  endtask

  function automatic logic [43:0] snap();
    return {bus.x_pos, bus.y_pos, bus.hsync, bus.vsync,
            bus.blank, bus.frame_start,
            bus.scroll_x, bus.scroll_y};
  endfunction

  function automatic logic [23:0] core();
    return {bus.x_pos, bus.y_pos, bus.hsync, bus.vsync,
            bus.blank, bus.frame_start};
  endfunction

  function automatic logic [43:0] mk(int x, int y, bit hs, bit vs,
                                     bit bl, bit fs, int sx, int sy);
    return {10'(x), 10'(y), hs, vs, bl, fs, 10'(sx), 10'(sy)};
  endfunction

  function automatic logic [23:0] mkc(int x, int y, bit hs, bit vs,
                                      bit bl, bit fs);
    return {10'(x), 10'(y), hs, vs, bl, fs};
  endfunction

  initial begin
    vt[0]  = '{0,   0, 0, 1000, 30, 1, 1, 0, 1, 1000, 30};
    vt[1]  = '{0,   1, 0, 1000, 30, 1, 1, 0, 0, 1001, 30};
    vt[2]  = '{0, 639, 0, 1000, 30, 1, 1, 0, 0,  615, 30};
    vt[3]  = '{0, 640, 0, 1000, 30, 1, 1, 1, 0,  616, 30};
    vt[4]  = '{0, 655, 0, 1000, 30, 1, 1, 1, 0,  631, 30};
    vt[5]  = '{0, 656, 0, 1000, 30, 0, 1, 1, 0,  632, 30};
    vt[6]  = '{0, 751, 0, 1000, 30, 0, 1, 1, 0,  727, 30};
    vt[7]  = '{0, 752, 0, 1000, 30, 1, 1, 1, 0,  728, 30};
    vt[8]  = '{0, 100, 5, 1000, 30, 1, 1, 0, 0,   76, 35};
    vt[9]  = '{0, 639, 5,    5,  5, 1, 1, 0, 0,  615, 35};
    vt[10] = '{0, 640, 5,    5,  5, 1, 1, 1, 0,  616, 35};
    vt[11] = '{0,   0, 6,    5,  5, 1, 1, 1, 0, 1000, 36};
    vt[12] = '{0,   0, 7,    5,  5, 1, 0, 1, 0, 1000, 37};
    vt[13] = '{0, 799, 8,    5,  5, 1, 0, 1, 0,  775, 38};
    vt[14] = '{0,   0, 9,    5,  5, 1, 1, 1, 0, 1000, 39};
    vt[15] = '{1,   0, 0,    5,  5, 1, 1, 0, 1,    5,  5};
    vt[16] = '{1, 100, 5,    5,  5, 1, 1, 0, 0,  105, 10};

    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.shot_req = 1'b0;
    bus.x_offset = '0;
    bus.y_offset = '0;
    #1;
    chk("reset_state", 64'(snap()), 64'(mk(0, 0, 1, 1, 1, 0, 0, 0)));
    chk("reset_shot", 64'({bus.shot_active, bus.shot_done}), 64'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("idle_hold", 64'(core()), 64'(mkc(0, 0, 1, 1, 1, 0)));

    bus.x_offset = 10'd1000;
    bus.y_offset = 10'd30;
    bus.enable   = 1'b1;
    tick();
    t = 0;

    for (int i = 0; i < 17; i++) begin
      bus.x_offset = 10'(vt[i].xo);
      bus.y_offset = 10'(vt[i].yo);
      goto(vt[i].f, vt[i].x, vt[i].y);
      chk($sformatf("vec%0d", i), 64'(snap()),
          64'(mk(vt[i].x, vt[i].y, vt[i].hs, vt[i].vs, vt[i].bl,
                 vt[i].fs, vt[i].sx, vt[i].sy)));
    end

    // screenshot armed mid-frame, request held high
    bus.shot_req = 1'b1;
    act_n  = 0;
    done_n = 0;
    goto(2, 0, 0);
    chk("shot_rise", 64'({bus.shot_active, bus.frame_start}), 64'b11);
    goto(3, 10, 0);
    chk("shot_len", 64'(act_n), 64'(FR));
    chk("shot_done_n", 64'(done_n), 64'd1);
    chk("shot_done_t", 64'(done_t), 64'(3 * FR));
    chk("shot_no_rearm", 64'(bus.shot_active), 64'd0);
    bus.shot_req = 1'b0;

    // request rising in the frame_start clock waits one frame
    goto(4, 0, 0);
    chk("fs_period", 64'(bus.frame_start), 64'd1);
    bus.shot_req = 1'b1;
    chk("same_fs_act", 64'(bus.shot_active), 64'd0);
    goto(4, 1, 0);
    chk("same_fs_next", 64'(bus.shot_active), 64'd0);
    goto(5, 0, 0);
    chk("same_fs_cap", 64'(bus.shot_active), 64'd1);

    // asynchronous reset during the capture
    d0 = done_n;
    goto(5, 400, 3);
    chk("cap_mid", 64'({bus.shot_active, bus.x_pos, bus.y_pos}),
        64'({1'b1, 10'd400, 10'd3}));
    reset        = 1'b0;
    bus.shot_req = 1'b0;
    #1;
    chk("async_rst", 64'(snap()), 64'(mk(0, 0, 1, 1, 1, 0, 0, 0)));
    chk("async_shot", 64'({bus.shot_active, bus.shot_done}), 64'd0);
    tick();
    tick();
    tick();
    chk("rst_no_done", 64'(done_n), 64'(d0));
    #1;
    reset = 1'b1;
    tick();
    t = 0;
    chk("restart", 64'(snap()), 64'(mk(0, 0, 1, 1, 0, 1, 5, 5)));

    // enable drop drains the frame; armed request is discarded
    d0 = done_n;
    goto(0, 5, 3);
    bus.shot_req = 1'b1;
    goto(0, 10, 3);
    bus.enable = 1'b0;
    goto(0, 100, 5);
    chk("drain_mid", 64'(snap()), 64'(mk(100, 5, 1, 1, 0, 0, 105, 10)));
    goto(0, 799, 9);
    chk("drain_end", 64'(core()), 64'(mkc(799, 9, 1, 1, 1, 0)));
    tick();
    chk("drain_idle", 64'(core()), 64'(mkc(0, 0, 1, 1, 1, 0)));
    tick();
    tick();
    tick();
    chk("idle_stay", 64'(core()), 64'(mkc(0, 0, 1, 1, 1, 0)));
    chk("idle_shot", 64'({bus.shot_active, bus.shot_done}), 64'd0);

    // re-enable during drain keeps the raster running
    bus.enable = 1'b1;
    tick();
    t = 0;
    chk("reenter", 64'({bus.frame_start, bus.shot_active}), 64'b10);
    goto(0, 10, 3);
    bus.enable = 1'b0;
    goto(0, 5, 5);
    bus.enable = 1'b1;
    goto(1, 0, 0);
    chk("no_gap", 64'(core()), 64'(mkc(0, 0, 1, 1, 0, 1)));
    chk("discard", 64'({bus.shot_active, 8'(done_n - d0)}), 64'd0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
